// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks two NUM_BITS operands LSB-first through a
// single one-bit full adder, one bit per clock, and reports sum, carry and overflow.

module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);
   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int NUM_BITS = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic                abort,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] sum,
   output logic                carry_out,
   output logic                overflow
);
   localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] a_q, b_q, sum_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                carry_q, carry_out_q, overflow_q;
   logic                add_sum, add_carry;
   logic                last_bit;

   adder_1bit u_adder (
      .a         (a_q[0]),
      .b         (b_q[0]),
      .carry_in  (carry_q),
      .sum       (add_sum),
      .carry_out (add_carry)
   );

   assign last_bit = (cnt_q == LAST_BIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ADD;
         ADD: begin
            if (abort)         state_d = IDLE;
            else if (last_bit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q         <= a;
                  b_q         <= b;
                  carry_q     <= carry_in;
                  cnt_q       <= '0;
                  sum_q       <= '0;
                  carry_out_q <= 1'b0;
                  overflow_q  <= 1'b0;
               end
            end
            ADD: begin
               if (abort) begin
                  sum_q       <= '0;
                  carry_out_q <= 1'b0;
                  overflow_q  <= 1'b0;
               end else begin
                  sum_q   <= {add_sum, sum_q[NUM_BITS-1:1]};
                  a_q     <= a_q >> 1;
                  b_q     <= b_q >> 1;
                  carry_q <= add_carry;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  // On the MSB step carry_q is still the carry into the MSB.
                  if (last_bit) begin
                     carry_out_q <= add_carry;
                     overflow_q  <= carry_q ^ add_carry;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q == ADD);
   assign done      = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (NUM_BITS=8) with hand-computed results.

module tb_serial_add_ctrl;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          start, abort, carry_in;
   logic [NB-1:0] a, b;
   logic          busy, done, carry_out, overflow;
   logic [NB-1:0] sum;

   int vectors     = 0;
   int miscompares = 0;

   serial_add_ctrl #(.NUM_BITS(NB)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .abort     (abort),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge after
   // the done cycle, which is the first IDLE cycle.
   task automatic run_add(input string tag, input logic [NB-1:0] av, input logic [NB-1:0] bv,
                          input logic cin, input logic [NB-1:0] es, input logic eco,
                          input logic eov);
      int lat = 0;
      int busy_cnt = 0;
      a = av; b = bv; carry_in = cin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, lat, NB);
      check({tag, " busy_cycles"}, busy_cnt, NB);
      check({tag, " busy_in_done"}, busy, 0);
      check({tag, " sum"}, sum, es);
      check({tag, " carry_out"}, carry_out, eco);
      check({tag, " overflow"}, overflow, eov);
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " sum_held"}, sum, es);
   endtask

   initial begin
      int dones;
      n_rst = 1'b0; start = 1'b0; abort = 1'b0; carry_in = 1'b0; a = '0; b = '0;
      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset flags", {carry_out, overflow}, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      run_add("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
      run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_add("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_add("add_00_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

      // Start held high through ADD and DONE with operands changing underneath.
      a = 8'h80; b = 8'h80; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 8'h01; b = 8'h01;
      dones = 0;
      for (int i = 0; i < NB; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("hold done_pulse", done, 1);
      check("hold sum", sum, 8'h00);
      check("hold carry_out", carry_out, 1);
      check("hold overflow", overflow, 1);
      @(negedge clk);
      check("hold idle_busy", busy, 0);
      check("hold idle_done", done, 0);
      check("hold early_dones", dones, 0);
      @(negedge clk);
      check("hold recapture_busy", busy, 1);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            dones++;
            check("hold second_sum", sum, 8'h02);
         end
         @(negedge clk);
      end
      check("hold second_dones", dones, 1);

      // Abort in the 4th ADD cycle.
      a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort still_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sum", sum, 0);
      check("abort flags", {carry_out, overflow}, 0);
      dones = 0;
      repeat (10) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      check("abort no_done", dones, 0);
      run_add("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // Asynchronous reset between edges in mid-ADD.
      a = 8'hFF; b = 8'hFF; carry_in = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset sum_nonzero", (sum != 0), 1);
      #2 n_rst = 1'b0;
      #1;
      check("async_reset busy", busy, 0);
      check("async_reset sum", sum, 0);
      check("async_reset flags", {done, carry_out, overflow}, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      run_add("after_reset", 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0);

      // Back-to-back: each start issued in the first IDLE cycle after DONE.
      run_add("b2b_0", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
      run_add("b2b_1", 8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1);
      run_add("b2b_2", 8'h9C, 8'h9C, 1'b1, 8'h39, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
